// File: rtl/microtile_share_arbiter_pkg.sv
// Shared types and defaults for the microtile share arbiter and its helpers.
package microtile_share_pkg;

    localparam int NUM_REQ_DEF       = 4;
    localparam int SETTLE_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } share_state_e;

endpackage

// File: rtl/microtile_share_arbiter_if.sv
// Bus between requesters, the arbiter and the shared combinational tile.
interface microtile_share_arbiter_if
    import microtile_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           ui_in;
    logic [7:0]           uo_out;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [7:0]           rsp_data;
    logic                 busy;

    // Arbiter side
    modport slave (
        input  req, req_data, uo_out,
        output grant, ui_in, rsp_valid, rsp_id, rsp_data, busy
    );

    // Requester / tile side
    modport master (
        output req, req_data, uo_out,
        input  grant, ui_in, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/microtile_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_winner
);
    int w_idx;

    // Scan from farthest to nearest so the closest set bit to ptr is written last.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (i_req[w_idx]) begin
                o_any    = 1'b1;
                o_winner = ID_W'(w_idx);
            end
        end
    end
endmodule

// File: rtl/microtile_share_arbiter.sv
// Shares one combinational microtile among NUM_REQ requesters: grant, drive
// ui_in, wait SETTLE_CYCLES, capture uo_out and return it tagged with the ID.
module microtile_share_arbiter
    import microtile_share_pkg::*;
#(
    parameter int NUM_REQ       = NUM_REQ_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst_n,
    microtile_share_arbiter_if.slave bus
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    share_state_e       r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id_q;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]         r_ui_in;
    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [7:0]         r_rsp_data;

    logic               w_any;
    logic [ID_W-1:0]    w_winner;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: a request starts a transaction, the counter ends SETTLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = SETTLE;
            SETTLE:  if (r_cnt == '0) w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers: grant/launch on the IDLE edge, count in SETTLE,
    // capture the tile result in CAPTURE. ui_in is only touched on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_id_q      <= '0;
            r_grant     <= '0;
            r_ui_in     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_grant     <= '0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ui_in <= bus.req_data[8*int'(w_winner) +: 8];
                        r_grant <= NUM_REQ'(1) << w_winner;
                        r_id_q  <= w_winner;
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_ptr   <= (int'(w_winner) == NUM_REQ - 1) ? '0
                                                                   : w_winner + ID_W'(1);
                    end
                end
                SETTLE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    r_rsp_data  <= bus.uo_out;
                    r_rsp_id    <= r_id_q;
                    r_rsp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ui_in     = r_ui_in;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state != IDLE);
endmodule
